// File: rtl/shifter_pkg.sv
// shifter_pkg: mode/direction encodings and fill selection shared by the barrel shifter.
package shifter_pkg;
  localparam logic [1:0] MODE_LOG = 2'b00;
  localparam logic [1:0] MODE_ARI = 2'b01;
  localparam logic [1:0] MODE_ROT = 2'b10;
  localparam logic [1:0] MODE_RSV = 2'b11;
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;
  // Only arithmetic right shifts bring in anything other than zeros; rotate ignores fill.
  function automatic logic fill_bit(input logic [1:0] mode, input logic dir, input logic msb);
    return (mode == MODE_ARI && dir == DIR_RIGHT) ? msb : 1'b0;
  endfunction
endpackage

// File: rtl/shift_stage.sv
// shift_stage: one conditional shift/rotate by DIST bits in either direction.
module shift_stage
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_en,
  input  logic             i_dir,
  input  logic [1:0]       i_mode,
  input  logic             i_fill,
  output logic [WIDTH-1:0] o_data
);
  logic             w_rot;
  logic [WIDTH-1:0] w_left;
  logic [WIDTH-1:0] w_right;
  always_comb begin
    w_rot   = i_mode == MODE_ROT;
    w_left  = {i_data[WIDTH-DIST-1:0], w_rot ? i_data[WIDTH-1:WIDTH-DIST] : {DIST{i_fill}}};
    w_right = {w_rot ? i_data[DIST-1:0] : {DIST{i_fill}}, i_data[WIDTH-1:DIST]};
    o_data  = !i_en ? i_data : (i_dir == DIR_LEFT ? w_left : w_right);
  end
endmodule

// File: rtl/barrel_shifter_pipe.sv
// barrel_shifter_pipe: pipelined logical/arithmetic/rotate barrel shifter with valid/ready flow control.
// Each register stage holds a beat still awaiting shift bit k; its shift feeds the next stage (or dout).
module barrel_shifter_pipe
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SH_W  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] din,
  input  logic [SH_W-1:0]  sh_amt,
  input  logic             dir,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout
);
  logic w_adv;
  assign w_adv    = out_ready | ~out_valid;
  assign in_ready = w_adv;
  genvar k;
  for (k = 0; k < SH_W; k++) begin : g_st
    logic [WIDTH-1:0]  r_data;
    logic [WIDTH-1:0]  w_shift;
    logic [SH_W-k-1:0] r_amt;
    logic              r_dir;
    logic [1:0]        r_mode;
    logic              r_msb;
    logic              r_valid;
    logic [WIDTH-1:0]  w_nd;
    logic [SH_W-k-1:0] w_na;
    logic              w_ndir;
    logic [1:0]        w_nmode;
    logic              w_nmsb;
    logic              w_nv;
    if (k == 0) begin : g_src
      always_comb begin
        w_nd    = din;
        w_na    = sh_amt;
        w_ndir  = dir;
        w_nmode = mode;
        w_nmsb  = din[WIDTH-1];
        w_nv    = in_valid;
      end
    end else begin : g_src
      // Drop the amount bit the previous stage just consumed.
      always_comb begin
        w_nd    = g_st[k-1].w_shift;
        w_na    = g_st[k-1].r_amt[SH_W-k:1];
        w_ndir  = g_st[k-1].r_dir;
        w_nmode = g_st[k-1].r_mode;
        w_nmsb  = g_st[k-1].r_msb;
        w_nv    = g_st[k-1].r_valid;
      end
    end
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_data  <= '0;
        r_amt   <= '0;
        r_dir   <= 1'b0;
        r_mode  <= MODE_LOG;
        r_msb   <= 1'b0;
        r_valid <= 1'b0;
      end else if (w_adv) begin
        r_data  <= w_nd;
        r_amt   <= w_na;
        r_dir   <= w_ndir;
        r_mode  <= w_nmode;
        r_msb   <= w_nmsb;
        r_valid <= w_nv;
      end
    end
    shift_stage #(
      .WIDTH(WIDTH),
      .DIST (1 << k)
    ) u_stage (
      .i_data(r_data),
      .i_en  (r_amt[0]),
      .i_dir (r_dir),
      .i_mode(r_mode),
      .i_fill(fill_bit(r_mode, r_dir, r_msb)),
      .o_data(w_shift)
    );
  end
  assign dout      = g_st[SH_W-1].w_shift;
  assign out_valid = g_st[SH_W-1].r_valid;
endmodule
